glitc_trigger_scaler_bank: RTL and testbench

- Parametrised multi-channel trigger scaler bank; next generation of the two-channel DSP scaler.
- Counts trigger events on NUM_CHANNELS inputs, each channel with a saturating WIDTH-bit counter.
- A single-cycle update strobe snapshots every counter into a storage bank and restarts counting without losing events.
- Housekeeping reads stored values by channel address. Level or rising-edge counting is selectable.

---
 rtl/glitc_trigger_scaler_bank.sv | 134 +++++++++++++
 tb/tb_glitc_trigger_scaler_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/glitc_trigger_scaler_bank.sv
// glitc_trigger_scaler_bank
//   Multi-channel trigger scaler bank. Each channel has a saturating
//   WIDTH-bit event counter with a sticky saturation flag. A one-cycle
//   update strobe copies every counter and flag into a storage bank and
//   restarts counting in the same cycle. The restarted counter includes that
//   cycle's event, so no event is dropped or counted twice at the boundary.
//   Stored values are read back by channel address with one cycle of latency.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_n_i        synchronous reset, active low
//   trigger_i      per-channel trigger level
//   update_i       snapshot-and-restart strobe (one cycle per request)
//   rd_req_i       read request
//   rd_addr_i      channel to read
//   rd_data_o      stored count of the addressed channel
//   rd_sat_o       stored saturation flag of the addressed channel
//   rd_valid_o     rd_data_o / rd_sat_o valid
//   update_done_o  one-cycle pulse in the cycle after a snapshot

module glitc_trigger_scaler_bank #(
  parameter  int NUM_CHANNELS = 8,
  parameter  int WIDTH        = 24,
  parameter  int EDGE_MODE    = 0,
  localparam int ADDR_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NUM_CHANNELS-1:0] trigger_i,
  input  logic                    update_i,
  input  logic                    rd_req_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  output logic [WIDTH-1:0]        rd_data_o,
  output logic                    rd_sat_o,
  output logic                    rd_valid_o,
  output logic                    update_done_o
);

  localparam logic             EDGE    = (EDGE_MODE != 0);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0]        cnt_q       [NUM_CHANNELS];
  logic [WIDTH-1:0]        cnt_d       [NUM_CHANNELS];
  logic [WIDTH-1:0]        store_q     [NUM_CHANNELS];
  logic [WIDTH-1:0]        store_d     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] sat_q, sat_d;
  logic [NUM_CHANNELS-1:0] store_sat_q, store_sat_d;
  logic [NUM_CHANNELS-1:0] prev_q;
  logic [NUM_CHANNELS-1:0] event_w;

  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_sat_q, rd_sat_d;
  logic             rd_valid_q, rd_valid_d;
  logic             update_done_q;

  // In level mode the history mask is all zeros, so the event is the raw
  // trigger. In edge mode a trigger already high right after reset is an
  // edge because the history resets to zero.
  assign event_w = trigger_i & ~(prev_q & {NUM_CHANNELS{EDGE}});

  always_comb begin
    sat_d       = sat_q;
    store_sat_d = store_sat_q;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      cnt_d[ch]   = cnt_q[ch];
      store_d[ch] = store_q[ch];
      if (update_i) begin
        // Snapshot takes the pre-event value; this cycle's event opens the
        // new period.
        store_d[ch]     = cnt_q[ch];
        store_sat_d[ch] = sat_q[ch];
        cnt_d[ch]       = event_w[ch] ? WIDTH'(1) : '0;
        sat_d[ch]       = 1'b0;
      end else if (event_w[ch]) begin
        if (cnt_q[ch] == CNT_MAX) begin
          sat_d[ch] = 1'b1;
        end else begin
          cnt_d[ch] = cnt_q[ch] + WIDTH'(1);
        end
      end
    end
  end

  // Address decode by compare, so out-of-range addresses fall through to 0.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_sat_d   = rd_sat_q;
    rd_valid_d = rd_req_i;
    if (rd_req_i) begin
      rd_data_d = '0;
      rd_sat_d  = 1'b0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (rd_addr_i == ADDR_W'(ch)) begin
          rd_data_d = store_q[ch];
          rd_sat_d  = store_sat_q[ch];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        cnt_q[ch]   <= '0;
        store_q[ch] <= '0;
      end
      sat_q         <= '0;
      store_sat_q   <= '0;
      prev_q        <= '0;
      rd_data_q     <= '0;
      rd_sat_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        cnt_q[ch]   <= cnt_d[ch];
        store_q[ch] <= store_d[ch];
      end
      sat_q         <= sat_d;
      store_sat_q   <= store_sat_d;
      prev_q        <= trigger_i;
      rd_data_q     <= rd_data_d;
      rd_sat_q      <= rd_sat_d;
      rd_valid_q    <= rd_valid_d;
      update_done_q <= update_i;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign rd_sat_o      = rd_sat_q;
  assign rd_valid_o    = rd_valid_q;
  assign update_done_o = update_done_q;

endmodule

// File: tb/tb_glitc_trigger_scaler_bank.sv
// tb_glitc_trigger_scaler_bank
//   Two instances: A = 8 channels, 24 bits, level mode;
//   B = 6 channels, 4 bits, edge mode. Expected read results are queued
//   when a read is issued and compared when rd_valid_o appears.

module tb_glitc_trigger_scaler_bank;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic rst_n = 1'b0;

  // instance A
  logic [7:0]  trig_a    = '0;
  logic        upd_a     = 1'b0;
  logic        rd_req_a  = 1'b0;
  logic [2:0]  rd_addr_a = '0;
  logic [23:0] rd_data_a;
  logic        rd_sat_a, rd_vld_a, done_a;

  // instance B
  logic [5:0]  trig_b    = '0;
  logic        upd_b     = 1'b0;
  logic        rd_req_b  = 1'b0;
  logic [2:0]  rd_addr_b = '0;
  logic [3:0]  rd_data_b;
  logic        rd_sat_b, rd_vld_b, done_b;

  glitc_trigger_scaler_bank #(.NUM_CHANNELS(8), .WIDTH(24), .EDGE_MODE(0)) u_dut_a (
    .clk_i(clk_sys), .rst_n_i(rst_n), .trigger_i(trig_a), .update_i(upd_a),
    .rd_req_i(rd_req_a), .rd_addr_i(rd_addr_a), .rd_data_o(rd_data_a),
    .rd_sat_o(rd_sat_a), .rd_valid_o(rd_vld_a), .update_done_o(done_a));

  glitc_trigger_scaler_bank #(.NUM_CHANNELS(6), .WIDTH(4), .EDGE_MODE(1)) u_dut_b (
    .clk_i(clk_sys), .rst_n_i(rst_n), .trigger_i(trig_b), .update_i(upd_b),
    .rd_req_i(rd_req_b), .rd_addr_i(rd_addr_b), .rd_data_o(rd_data_b),
    .rd_sat_o(rd_sat_b), .rd_valid_o(rd_vld_b), .update_done_o(done_b));

  int total = 0;
  int bad   = 0;

  logic [24:0] q_a [$];   // {sat, data}
  logic [4:0]  q_b [$];

  logic exp_vld_a = 1'b0, exp_done_a = 1'b0;
  logic exp_vld_b = 1'b0, exp_done_b = 1'b0;

  always @(posedge clk_sys) begin
    exp_vld_a  <= rd_req_a & rst_n;
    exp_done_a <= upd_a & rst_n;
    exp_vld_b  <= rd_req_b & rst_n;
    exp_done_b <= upd_b & rst_n;
  end

  always @(negedge clk_sys) begin
    logic [24:0] ea;
    logic [4:0]  eb;
    total++;
    assert (done_a === exp_done_a) else begin
      bad++; $error("FAIL done_a observed=%0b expected=%0b", done_a, exp_done_a);
    end
    total++;
    assert (rd_vld_a === exp_vld_a) else begin
      bad++; $error("FAIL valid_a observed=%0b expected=%0b", rd_vld_a, exp_vld_a);
    end
    if (rd_vld_a === 1'b1) begin
      total++;
      assert (q_a.size() != 0) else begin
        bad++; $error("FAIL unexpected_read_a observed=valid expected=no_pending_read");
      end
      if (q_a.size() != 0) begin
        ea = q_a.pop_front();
        total++;
        assert (rd_data_a === ea[23:0]) else begin
          bad++; $error("FAIL data_a observed=%0d expected=%0d", rd_data_a, ea[23:0]);
        end
        total++;
        assert (rd_sat_a === ea[24]) else begin
          bad++; $error("FAIL sat_a observed=%0b expected=%0b", rd_sat_a, ea[24]);
        end
      end
    end
    total++;
    assert (done_b === exp_done_b) else begin
      bad++; $error("FAIL done_b observed=%0b expected=%0b", done_b, exp_done_b);
    end
    total++;
    assert (rd_vld_b === exp_vld_b) else begin
      bad++; $error("FAIL valid_b observed=%0b expected=%0b", rd_vld_b, exp_vld_b);
    end
    if (rd_vld_b === 1'b1) begin
      total++;
      assert (q_b.size() != 0) else begin
        bad++; $error("FAIL unexpected_read_b observed=valid expected=no_pending_read");
      end
      if (q_b.size() != 0) begin
        eb = q_b.pop_front();
        total++;
        assert (rd_data_b === eb[3:0]) else begin
          bad++; $error("FAIL data_b observed=%0d expected=%0d", rd_data_b, eb[3:0]);
        end
        total++;
        assert (rd_sat_b === eb[4]) else begin
          bad++; $error("FAIL sat_b observed=%0b expected=%0b", rd_sat_b, eb[4]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic rd_a(input logic [2:0] addr, input logic [23:0] d, input logic s);
    rd_req_a = 1'b1; rd_addr_a = addr; q_a.push_back({s, d});
    tick(1);
    rd_req_a = 1'b0;
  endtask

  task automatic rd_b(input logic [2:0] addr, input logic [3:0] d, input logic s);
    rd_req_b = 1'b1; rd_addr_b = addr; q_b.push_back({s, d});
    tick(1);
    rd_req_b = 1'b0;
  endtask

  task automatic update_a();
    upd_a = 1'b1; tick(1); upd_a = 1'b0;
  endtask

  task automatic update_b();
    upd_b = 1'b1; tick(1); upd_b = 1'b0;
  endtask

  initial begin
    // reset for 3 cycles; B's edge pattern begins the first cycle after reset
    tick(3);
    rst_n = 1'b1;
    trig_b[2] = 1'b1; tick(1);
    trig_b[2] = 1'b1; tick(1);
    trig_b[2] = 1'b0; tick(1);
    trig_b[2] = 1'b1; tick(1);
    trig_b[2] = 1'b0; tick(1);
    trig_b[2] = 1'b1; tick(3);
    trig_b[2] = 1'b0;

    // A idle: all channels read zero
    for (int ch = 0; ch < 8; ch++) rd_a(3'(ch), 24'd0, 1'b0);

    // B edge count: 3 rising edges
    update_b();
    rd_b(3'd2, 4'd3, 1'b0);

    // B out-of-range addresses
    rd_b(3'd6, 4'd0, 1'b0);
    rd_b(3'd7, 4'd0, 1'b0);

    // B saturation: 20 edges into a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      trig_b[1] = 1'b1; tick(1);
      trig_b[1] = 1'b0; tick(1);
    end
    update_b();
    rd_b(3'd1, 4'd15, 1'b1);
    // exactly 15 edges reach max without dropping one
    for (int i = 0; i < 15; i++) begin
      trig_b[1] = 1'b1; tick(1);
      trig_b[1] = 1'b0; tick(1);
    end
    update_b();
    rd_b(3'd1, 4'd15, 1'b0);

    // A level count: ch3 high 100 cycles, ch5 high the first 7
    trig_a = 8'b0010_1000;
    tick(7);
    trig_a[5] = 1'b0;
    tick(93);
    trig_a = '0;
    update_a();
    rd_a(3'd3, 24'd100, 1'b0);
    rd_a(3'd5, 24'd7, 1'b0);

    // A boundary: ch0 high 10 cycles, update in the 11th, then 9 more
    trig_a[0] = 1'b1;
    tick(10);
    update_a();
    rd_a(3'd0, 24'd10, 1'b0);
    tick(8);
    trig_a[0] = 1'b0;
    tick(2);
    update_a();
    rd_a(3'd0, 24'd10, 1'b0);
    rd_a(3'd3, 24'd0, 1'b0);

    // A read/update collision on ch4
    trig_a[4] = 1'b1; tick(42); trig_a[4] = 1'b0;
    update_a();
    trig_a[4] = 1'b1; tick(9); trig_a[4] = 1'b0;
    upd_a = 1'b1; rd_req_a = 1'b1; rd_addr_a = 3'd4; q_a.push_back({1'b0, 24'd42});
    tick(1);
    upd_a = 1'b0; rd_req_a = 1'b0;
    rd_a(3'd4, 24'd9, 1'b0);

    // A reset mid-operation: stored 5 and in-flight 4 are discarded,
    // read and update sampled during reset are ignored
    trig_a[3] = 1'b1; tick(5); trig_a[3] = 1'b0;
    update_a();
    rd_a(3'd3, 24'd5, 1'b0);
    trig_a[3] = 1'b1; tick(4); trig_a[3] = 1'b0;
    rst_n = 1'b0; upd_a = 1'b1; rd_req_a = 1'b1; rd_addr_a = 3'd3;
    upd_b = 1'b1; rd_req_b = 1'b1; rd_addr_b = 3'd1;
    tick(1);
    rst_n = 1'b1; upd_a = 1'b0; rd_req_a = 1'b0; upd_b = 1'b0; rd_req_b = 1'b0;
    tick(1);
    rd_a(3'd3, 24'd0, 1'b0);
    rd_b(3'd1, 4'd0, 1'b0);
    update_a();
    rd_a(3'd3, 24'd0, 1'b0);

    tick(3);
    total++;
    assert (q_a.size() == 0) else begin
      bad++; $error("FAIL pending_a observed=%0d expected=0", q_a.size());
    end
    total++;
    assert (q_b.size() == 0) else begin
      bad++; $error("FAIL pending_b observed=%0d expected=0", q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
